cache_set_assoc: RTL and testbench

Parametrised N-way set-associative cache tag/state controller. It is the successor to the fixed 16-block direct-mapped tag model and keeps the same simulated-data style: no data array, and `resp_data` is a fixed pattern. It adds ways with true-LRU replacement, write-back/write-allocate with dirty tracking and eviction reporting, a valid/ready request handshake, a multi-cycle flush FSM, and saturating hit/miss counters. It sits between the core request generator and the memory model.

---
 rtl/cache_set_assoc.sv | 136 +++++++++++++
 tb/tb_cache_set_assoc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cache_set_assoc.sv
// cache_set_assoc: N-way set-associative tag/state controller with true-LRU, write-back dirty tracking and flush
module cache_set_assoc #(
   parameter int ADDR_W = 11,
   parameter int OFFSET_W = 4,
   parameter int INDEX_W = 3,
   parameter int WAYS = 2,
   parameter int CNT_W = 16,
   parameter logic [ADDR_W-1:0] DATA_PAT = 'h3F3
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_write,
   input  logic [ADDR_W-1:0] req_addr,
   output logic resp_valid,
   output logic resp_hit,
   output logic [$clog2(WAYS)-1:0] resp_way,
   output logic [ADDR_W-1:0] resp_data,
   output logic resp_evict,
   output logic [ADDR_W-1:0] resp_evict_addr,
   input  logic flush,
   output logic flush_done,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int SETS = 1 << INDEX_W;
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t state_q, state_d;
   logic [INDEX_W-1:0] ptr_q;
   logic [WAYS-1:0] valid_q [SETS];
   logic [WAYS-1:0] dirty_q [SETS];
   logic [TAG_W-1:0] tag_q [SETS][WAYS];
   logic [WAY_W-1:0] age_q [SETS][WAYS];
   logic [TAG_W-1:0] req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic unused_offset;
   logic accept, flush_start, flush_last;
   logic hit, inv_found, evict;
   logic [WAY_W-1:0] hit_way, inv_way, lru_way, way;
   assign req_tag = req_addr[ADDR_W-1:ADDR_W-TAG_W];
   assign req_idx = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign unused_offset = ^req_addr[OFFSET_W-1:0];
   assign req_ready = (state_q == IDLE) && !flush;
   assign accept = req_valid && req_ready;
   assign flush_start = (state_q == IDLE) && flush;
   assign flush_last = (state_q == FLUSH) && (ptr_q == INDEX_W'(SETS - 1));
   assign way = hit ? hit_way : inv_found ? inv_way : lru_way;
   assign evict = !hit && valid_q[req_idx][way] && dirty_q[req_idx][way];
   // tag match, first free way and LRU way of the addressed set
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      inv_found = 1'b0;
      inv_way = '0;
      lru_way = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (valid_q[req_idx][i] && tag_q[req_idx][i] == req_tag) begin
            hit = 1'b1;
            hit_way = WAY_W'(i);
         end
         if (!valid_q[req_idx][i] && !inv_found) begin
            inv_found = 1'b1;
            inv_way = WAY_W'(i);
         end
         if (age_q[req_idx][i] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(i);
      end
   end
   // state register and flush set pointer
   always_ff @(posedge clk) begin
      state_q <= rst ? IDLE : state_d;
      ptr_q <= (rst || flush_start) ? '0 : (state_q == FLUSH) ? ptr_q + 1'b1 : ptr_q;
   end
   // next state: enter FLUSH on request, leave after the last set is cleared
   always_comb begin
      state_d = state_q;
      if (flush_start) state_d = FLUSH;
      else if (flush_last) state_d = IDLE;
   end
   // line state: reset/flush clear sets, accepts fill or mark dirty and age the set
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int i = 0; i < WAYS; i++) begin
               tag_q[s][i] <= '0;
               age_q[s][i] <= WAY_W'(i);
            end
         end
      end else if (state_q == FLUSH) begin
         valid_q[ptr_q] <= '0;
         dirty_q[ptr_q] <= '0;
         for (int i = 0; i < WAYS; i++) age_q[ptr_q][i] <= WAY_W'(i);
      end else if (accept) begin
         for (int i = 0; i < WAYS; i++)
            if (age_q[req_idx][i] < age_q[req_idx][way]) age_q[req_idx][i] <= age_q[req_idx][i] + 1'b1;
         age_q[req_idx][way] <= '0;
         if (!hit) begin
            tag_q[req_idx][way] <= req_tag;
            valid_q[req_idx][way] <= 1'b1;
            dirty_q[req_idx][way] <= req_write;
         end else if (req_write) begin
            dirty_q[req_idx][way] <= 1'b1;
         end
      end
   end
   // registered response, flush completion pulse and saturating statistics
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_hit <= 1'b0;
         resp_way <= '0;
         resp_data <= '0;
         resp_evict <= 1'b0;
         resp_evict_addr <= '0;
         flush_done <= 1'b0;
         hit_count <= '0;
         miss_count <= '0;
      end else begin
         resp_valid <= accept;
         flush_done <= flush_last;
         if (accept) begin
            resp_hit <= hit;
            resp_way <= way;
            resp_data <= DATA_PAT;
            resp_evict <= evict;
            resp_evict_addr <= {tag_q[req_idx][way], req_idx, {OFFSET_W{1'b0}}};
         end
         if (accept && hit && hit_count != '1) hit_count <= hit_count + 1'b1;
         if (accept && !hit && miss_count != '1) miss_count <= miss_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_cache_set_assoc.sv
// tb_cache_set_assoc: directed table-driven checks of hits, LRU fills, evictions, flush and counter saturation
module tb_cache_set_assoc;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req_valid = 1'b0, req_write = 1'b0, flush = 1'b0;
   logic [10:0] req_addr = '0;
   logic req_ready, resp_valid, resp_hit, resp_evict, flush_done;
   logic [0:0] resp_way;
   logic [10:0] resp_data, resp_evict_addr;
   logic [15:0] hit_count, miss_count;
   logic q_valid = 1'b0, q_write = 1'b0, q_flush = 1'b0;
   logic [10:0] q_addr = '0;
   logic q_ready, q_resp_valid, q_resp_hit, q_resp_evict, q_flush_done;
   logic [0:0] q_resp_way;
   logic [10:0] q_resp_data, q_resp_evict_addr;
   logic [3:0] q_hit_count, q_miss_count;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic rst_b;
      logic wr;
      logic [10:0] addr;
      logic hit;
      logic [0:0] way;
      logic ev;
      logic [10:0] eaddr;
      int hc;
      int mc;
   } vec_t;
   vec_t tbl [10];

   always #5 clk = ~clk;

   cache_set_assoc dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
      .resp_data(resp_data), .resp_evict(resp_evict), .resp_evict_addr(resp_evict_addr),
      .flush(flush), .flush_done(flush_done), .hit_count(hit_count), .miss_count(miss_count)
   );

   cache_set_assoc #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(q_valid), .req_ready(q_ready), .req_write(q_write),
      .req_addr(q_addr), .resp_valid(q_resp_valid), .resp_hit(q_resp_hit), .resp_way(q_resp_way),
      .resp_data(q_resp_data), .resp_evict(q_resp_evict), .resp_evict_addr(q_resp_evict_addr),
      .flush(q_flush), .flush_done(q_flush_done), .hit_count(q_hit_count), .miss_count(q_miss_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic [10:0] a, input logic h,
                               input logic [0:0] wy, input logic e, input logic [10:0] ea,
                               input int hc, input int mc);
      vec_t v;
      v.rst_b = r; v.wr = w; v.addr = a; v.hit = h; v.way = wy;
      v.ev = e; v.eaddr = ea; v.hc = hc; v.mc = mc;
      return v;
   endfunction

   initial begin
      int nresp;
      int npulse;
      tbl[0] = mk(0, 0, 11'h123, 0, 0, 0, 0, 0, 1);
      tbl[1] = mk(0, 0, 11'h12F, 1, 0, 0, 0, 1, 1);
      tbl[2] = mk(1, 0, 11'h020, 0, 0, 0, 0, 0, 1);
      tbl[3] = mk(0, 0, 11'h0A0, 0, 1, 0, 0, 0, 2);
      tbl[4] = mk(0, 0, 11'h020, 1, 0, 0, 0, 1, 2);
      tbl[5] = mk(0, 0, 11'h120, 0, 1, 0, 0, 1, 3);
      tbl[6] = mk(0, 0, 11'h0A0, 0, 0, 0, 0, 1, 4);
      tbl[7] = mk(1, 1, 11'h020, 0, 0, 0, 0, 0, 1);
      tbl[8] = mk(0, 0, 11'h0A0, 0, 1, 0, 0, 0, 2);
      tbl[9] = mk(0, 0, 11'h120, 0, 0, 1, 11'h020, 0, 3);

      do_reset();
      chk("reset req_ready", req_ready, 1);
      chk("reset resp_valid", resp_valid, 0);
      chk("reset resp_data", resp_data, 0);
      chk("reset flush_done", flush_done, 0);
      chk("reset hit_count", hit_count, 0);
      chk("reset miss_count", miss_count, 0);

      for (int k = 0; k < 10; k++) begin
         if (tbl[k].rst_b) begin
            req_valid = 1'b0;
            do_reset();
         end
         req_valid = 1'b1;
         req_write = tbl[k].wr;
         req_addr = tbl[k].addr;
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d resp_valid", k), resp_valid, 1);
         chk($sformatf("v%0d resp_hit", k), resp_hit, tbl[k].hit);
         chk($sformatf("v%0d resp_way", k), resp_way, tbl[k].way);
         chk($sformatf("v%0d resp_data", k), resp_data, 11'h3F3);
         chk($sformatf("v%0d resp_evict", k), resp_evict, tbl[k].ev);
         if (tbl[k].ev) chk($sformatf("v%0d evict_addr", k), resp_evict_addr, tbl[k].eaddr);
         chk($sformatf("v%0d hit_count", k), hit_count, tbl[k].hc);
         chk($sformatf("v%0d miss_count", k), miss_count, tbl[k].mc);
      end

      req_write = 1'b0;
      req_addr = 11'h0A0;
      flush = 1'b1;
      #1 chk("flush req_ready low", req_ready, 0);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      chk("flush no accept", resp_valid, 0);
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("flush c%0d ready", c), req_ready, 0);
         chk($sformatf("flush c%0d done", c), flush_done, 0);
         if (c > 0) chk($sformatf("flush c%0d resp_valid", c), resp_valid, 0);
         @(posedge clk);
         @(negedge clk);
      end
      chk("flush_done pulse", flush_done, 1);
      chk("flush ready back", req_ready, 1);
      chk("flush hit_count", hit_count, 0);
      chk("flush miss_count", miss_count, 3);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("flush_done single", flush_done, 0);
      chk("post flush resp_valid", resp_valid, 1);
      chk("post flush hit", resp_hit, 0);
      chk("post flush way", resp_way, 0);
      chk("post flush evict", resp_evict, 0);
      chk("post flush miss_count", miss_count, 4);

      do_reset();
      q_valid = 1'b1;
      q_addr = 11'h040;
      nresp = 0;
      for (int c = 0; c < 21; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (q_resp_valid) nresp++;
         if (c == 0) chk("sat first miss", q_resp_hit, 0);
      end
      q_valid = 1'b0;
      chk("sat responses", nresp, 21);
      chk("sat hit_count", q_hit_count, 15);
      chk("sat miss_count", q_miss_count, 1);
      @(posedge clk);
      @(negedge clk);
      chk("sat idle resp_valid", q_resp_valid, 0);

      req_valid = 1'b1;
      req_addr = 11'h123;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("pre-rst miss_count", miss_count, 1);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst flush ready", req_ready, 1);
      chk("rst flush miss_count", miss_count, 0);
      chk("rst flush hit_count", hit_count, 0);
      chk("rst flush resp_data", resp_data, 0);
      npulse = 0;
      for (int c = 0; c < 12; c++) begin
         if (flush_done) npulse++;
         @(posedge clk);
         @(negedge clk);
      end
      chk("rst flush no done", npulse, 0);
      req_valid = 1'b1;
      req_addr = 11'h123;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst flush line invalid", resp_hit, 0);
      chk("rst flush refill way", resp_way, 0);
      chk("rst flush miss after", miss_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
